// File: rtl/crc_req_scheduler_pkg.sv
// Shared types and defaults for the CRC request scheduler.
// State encoding, default widths and a counter sizing helper.
package crc_sched_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_CRC_W  = 16;

   typedef enum logic [2:0] {
      ST_FLUSH,
      ST_IDLE,
      ST_LOAD,
      ST_FEED,
      ST_ZEROS,
      ST_READ,
      ST_DONE
   } state_t;

   function automatic int cnt_bits(input int a, input int b);
      return $clog2((a > b) ? a : b) + 1;
   endfunction

endpackage

// File: rtl/crc_req_scheduler_if.sv
// Requester-side bus of the CRC scheduler.
// master = requester group, slave = scheduler.
interface crc_req_scheduler_if #(
   parameter int N_REQ  = 2,
   parameter int DATA_W = crc_sched_pkg::DEF_DATA_W,
   parameter int CRC_W  = crc_sched_pkg::DEF_CRC_W
);

   logic [N_REQ-1:0]        REQ;
   logic [N_REQ*DATA_W-1:0] REQ_DATA;
   logic [N_REQ-1:0]        GNT;
   logic [N_REQ-1:0]        DONE;
   logic [CRC_W-1:0]        RESULT;
   logic                    BUSY;

   modport master (
      output REQ, REQ_DATA,
      input  GNT, DONE, RESULT, BUSY
   );

   modport slave (
      input  REQ, REQ_DATA,
      output GNT, DONE, RESULT, BUSY
   );

endinterface

// File: rtl/crc_req_scheduler_rr_arbiter.sv
// Round-robin pick: first request at or after ptr wins.
// Purely combinational; the pointer lives in the parent.
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   input  logic             en,
   output logic [N_REQ-1:0] gnt,
   output logic [PW-1:0]    idx
);

   logic found;
   int   j;

   // Scan requesters in rotated order starting at ptr
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (en && !found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = PW'(j);
         end
      end
   end

endmodule

// File: rtl/crc_req_scheduler.sv
// Shares one serial CRC engine among N_REQ requesters.
// Flush, arbitrate, feed word + zeros, read back CRC.
module crc_req_scheduler
   import crc_sched_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CRC_W  = DEF_CRC_W
) (
   input  logic               CLK,
   input  logic               RESET_N,
   crc_req_scheduler_if.slave req_bus,
   output logic               CRC_DATA,
   output logic               CRC_READ_MODE,
   input  logic               CRC_OUT
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = cnt_bits(DATA_W, CRC_W);
   localparam logic [CW-1:0] D_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] C_LAST = CW'(CRC_W - 1);
   localparam logic [PW-1:0] P_LAST = PW'(N_REQ - 1);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q;
   logic [PW-1:0]       ptr_q, idx_q, arb_idx;
   logic [N_REQ-1:0]    gnt_q, arb_gnt;
   logic [DATA_W-1:0]   sreg_q;
   logic [CRC_W-1:0]    cap_q, res_q;
   logic                in_cnt;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_arb (
      .req (req_bus.REQ),
      .ptr (ptr_q),
      .en  (state_q == ST_IDLE),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // State register; reset lands in FLUSH to drain the engine
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state_q <= ST_FLUSH;
      else          state_q <= state_d;
   end

   // Next-state logic; each timed phase exits on its last count
   always_comb begin
      state_d = state_q;
      in_cnt  = 1'b0;
      unique case (state_q)
         ST_FLUSH: begin
            in_cnt = 1'b1;
            if (cnt_q == C_LAST) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (|req_bus.REQ) state_d = ST_LOAD;
         end
         ST_LOAD: state_d = ST_FEED;
         ST_FEED: begin
            in_cnt = 1'b1;
            if (cnt_q == D_LAST) state_d = ST_ZEROS;
         end
         ST_ZEROS: begin
            in_cnt = 1'b1;
            if (cnt_q == C_LAST) state_d = ST_READ;
         end
         ST_READ: begin
            in_cnt = 1'b1;
            if (cnt_q == C_LAST) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_FLUSH;
      endcase
   end

   // Shared phase counter, restarts at every state change
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)               cnt_q <= '0;
      else if (state_d != state_q) cnt_q <= '0;
      else if (in_cnt)             cnt_q <= cnt_q + CW'(1);
   end

   // Grant, pointer, shift and capture registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         gnt_q  <= '0;
         idx_q  <= '0;
         ptr_q  <= '0;
         sreg_q <= '0;
         cap_q  <= '0;
         res_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|req_bus.REQ) begin
                  gnt_q <= arb_gnt;
                  idx_q <= arb_idx;
               end
            end
            ST_LOAD: begin
               sreg_q <= req_bus.REQ_DATA[idx_q*DATA_W +: DATA_W];
               ptr_q  <= (idx_q == P_LAST) ? '0 : idx_q + PW'(1);
            end
            ST_FEED:  sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
            ST_READ:  cap_q  <= {cap_q[CRC_W-2:0], CRC_OUT};
            ST_DONE: begin
               res_q <= cap_q;
               gnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign req_bus.GNT    = gnt_q;
   assign req_bus.DONE   = (state_q == ST_DONE) ? gnt_q : '0;
   assign req_bus.RESULT = res_q;
   assign req_bus.BUSY   = (state_q != ST_IDLE);

   assign CRC_DATA      = (state_q == ST_FEED) & sreg_q[DATA_W-1];
   assign CRC_READ_MODE = RESET_N &
                          ((state_q == ST_FLUSH) | (state_q == ST_READ));

endmodule

// File: tb/tb_crc_req_scheduler.sv
// Directed bench for crc_req_scheduler with a CRC-16 (0x1021) engine model.
// Engine is not reset with the DUT, so stale residue exercises the flush.
module tb_crc_req_scheduler;

   localparam int N_REQ  = 2;
   localparam int DATA_W = 16;
   localparam int CRC_W  = 16;
   localparam logic [15:0] POLY = 16'h1021;

   logic CLK = 1'b0;
   logic RESET_N;
   logic crc_data, crc_read_mode, crc_out;
   logic [15:0] eng = 16'hDEAD;

   int n_checks = 0;
   int n_fail   = 0;
   bit gnt_bad  = 0;

   crc_req_scheduler_if #(
      .N_REQ (N_REQ), .DATA_W (DATA_W), .CRC_W (CRC_W)
   ) bus ();

   crc_req_scheduler #(
      .N_REQ (N_REQ), .DATA_W (DATA_W), .CRC_W (CRC_W)
   ) dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .req_bus       (bus.slave),
      .CRC_DATA      (crc_data),
      .CRC_READ_MODE (crc_read_mode),
      .CRC_OUT       (crc_out)
   );

   always #5 CLK = ~CLK;

   // serial CRC engine: augmented division, read mode shifts out
   always @(posedge CLK) begin
      if (crc_read_mode) eng <= {eng[14:0], 1'b0};
      else eng <= {eng[14:0], crc_data} ^ (eng[15] ? POLY : 16'h0);
   end
   assign crc_out = eng[15];

   always @(negedge CLK) begin
      if ($countones(bus.GNT) > 1) gnt_bad = 1;
   end

   // reference CRC, direct (non-augmented) form, init 0
   function automatic logic [15:0] crc_ref(input logic [15:0] d);
      logic [15:0] c;
      logic fb;
      c = 16'h0;
      for (int i = 15; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c = {c[14:0], 1'b0};
         if (fb) c = c ^ POLY;
      end
      return c;
   endfunction

   // wait (bounded) until a DONE pulse is visible at a negedge
   task automatic wait_done(output int k, output bit to);
      k = 0;
      to = 0;
      while (bus.DONE == '0) begin
         @(negedge CLK);
         k++;
         if (k > 200) begin
            to = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int n;
      bit rd_bad;
      RESET_N = 1'b0;
      bus.REQ = '0;
      bus.REQ_DATA = '0;
      repeat (3) @(negedge CLK);
      n_checks++;
      if (bus.GNT !== 2'b00 || bus.DONE !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_gnt_done: gnt=%b done=%b want 00/00", bus.GNT, bus.DONE);
      end
      n_checks++;
      if (bus.RESULT !== 16'h0 || crc_data !== 1'b0 || crc_read_mode !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outs: result=%h data=%b rd=%b want 0000/0/0",
                  bus.RESULT, crc_data, crc_read_mode);
      end
      n_checks++;
      if (bus.BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_busy: busy=%b want 1", bus.BUSY);
      end
      RESET_N = 1'b1;
      #1;
      n = 0;
      rd_bad = 0;
      while (bus.BUSY === 1'b1 && n < 100) begin
         if (crc_read_mode !== 1'b1) rd_bad = 1;
         n++;
         @(negedge CLK);
      end
      n_checks++;
      if (n != 16) begin
         n_fail++;
         $display("FAIL flush_len: busy cycles=%0d want 16", n);
      end
      n_checks++;
      if (rd_bad) begin
         n_fail++;
         $display("FAIL flush_rd: read_mode low during flush, want 1");
      end
      n_checks++;
      if (bus.BUSY !== 1'b0 || bus.RESULT !== 16'h0) begin
         n_fail++;
         $display("FAIL idle_after_flush: busy=%b result=%h want 0/0000",
                  bus.BUSY, bus.RESULT);
      end
   endtask

   task automatic test_zero_job();
      int k;
      bit to;
      bus.REQ_DATA = '0;
      bus.REQ = 2'b01;
      @(negedge CLK);
      n_checks++;
      if (bus.GNT !== 2'b01) begin
         n_fail++;
         $display("FAIL zero_gnt: gnt=%b want 01", bus.GNT);
      end
      wait_done(k, to);
      n_checks++;
      if (to || k + 1 != 50) begin
         n_fail++;
         $display("FAIL zero_latency: latency=%0d want 50", k + 1);
      end
      n_checks++;
      if (bus.DONE !== 2'b01 || bus.GNT !== 2'b01) begin
         n_fail++;
         $display("FAIL zero_done: done=%b gnt=%b want 01/01", bus.DONE, bus.GNT);
      end
      bus.REQ = '0;
      @(negedge CLK);
      n_checks++;
      if (bus.DONE !== 2'b00 || bus.GNT !== 2'b00 || bus.RESULT !== 16'h0) begin
         n_fail++;
         $display("FAIL zero_after: done=%b gnt=%b result=%h want 00/00/0000",
                  bus.DONE, bus.GNT, bus.RESULT);
      end
   endtask

   task automatic test_stream();
      int k;
      bit to;
      logic [31:0] bits;
      logic [15:0] first;
      first = 16'h0;
      for (int rep = 0; rep < 2; rep++) begin
         bus.REQ_DATA = {16'h0, 16'hA5C3};
         bus.REQ = 2'b01;
         @(negedge CLK);
         bits = '0;
         for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            bits = {bits[30:0], crc_data};
         end
         n_checks++;
         if (bits !== 32'hA5C3_0000) begin
            n_fail++;
            $display("FAIL stream_bits: rep%0d bits=%h want a5c30000", rep, bits);
         end
         wait_done(k, to);
         n_checks++;
         if (to || bus.DONE !== 2'b01) begin
            n_fail++;
            $display("FAIL stream_done: rep%0d done=%b want 01", rep, bus.DONE);
         end
         bus.REQ = '0;
         @(negedge CLK);
         n_checks++;
         if (bus.RESULT !== crc_ref(16'hA5C3)) begin
            n_fail++;
            $display("FAIL stream_result: rep%0d result=%h want %h",
                     rep, bus.RESULT, crc_ref(16'hA5C3));
         end
         if (rep == 0) first = bus.RESULT;
         else begin
            n_checks++;
            if (bus.RESULT !== first) begin
               n_fail++;
               $display("FAIL stream_repeat: result=%h want %h", bus.RESULT, first);
            end
         end
      end
   endtask

   task automatic test_data_change();
      int k;
      bit to;
      bus.REQ_DATA = {16'h5A5A, 16'h0};
      bus.REQ = 2'b10;
      @(negedge CLK);
      n_checks++;
      if (bus.GNT !== 2'b10) begin
         n_fail++;
         $display("FAIL chg_gnt: gnt=%b want 10", bus.GNT);
      end
      repeat (3) @(negedge CLK);
      bus.REQ_DATA = {16'hFFFF, 16'h0};
      bus.REQ = 2'b00;
      wait_done(k, to);
      n_checks++;
      if (to || bus.DONE !== 2'b10) begin
         n_fail++;
         $display("FAIL chg_done: done=%b want 10", bus.DONE);
      end
      @(negedge CLK);
      n_checks++;
      if (bus.RESULT !== crc_ref(16'h5A5A)) begin
         n_fail++;
         $display("FAIL chg_result: result=%h want %h", bus.RESULT, crc_ref(16'h5A5A));
      end
   endtask

   task automatic test_round_robin();
      int k;
      bit to;
      logic [1:0] exp;
      logic [15:0] d;
      bus.REQ_DATA = {16'h2222, 16'h1111};
      bus.REQ = 2'b11;
      for (int i = 0; i < 4; i++) begin
         exp = (i % 2 == 0) ? 2'b01 : 2'b10;
         d = (i % 2 == 0) ? 16'h1111 : 16'h2222;
         wait_done(k, to);
         n_checks++;
         if (to || bus.DONE !== exp) begin
            n_fail++;
            $display("FAIL rr_order: job%0d done=%b want %b", i, bus.DONE, exp);
         end
         if (i == 3) bus.REQ = '0;
         @(negedge CLK);
         n_checks++;
         if (bus.DONE !== 2'b00 || bus.RESULT !== crc_ref(d)) begin
            n_fail++;
            $display("FAIL rr_pulse: job%0d done=%b result=%h want 00/%h",
                     i, bus.DONE, bus.RESULT, crc_ref(d));
         end
      end
      n_checks++;
      if (gnt_bad) begin
         n_fail++;
         $display("FAIL gnt_onehot: two-hot GNT seen=%b want 0", gnt_bad);
      end
   endtask

   task automatic test_reset_mid();
      int k, n;
      bit to, saw_done;
      bus.REQ_DATA = {16'h0, 16'h1234};
      bus.REQ = 2'b01;
      @(negedge CLK);
      repeat (19) @(negedge CLK);
      RESET_N = 1'b0;
      bus.REQ = '0;
      #1;
      n_checks++;
      if (bus.GNT !== 2'b00 || bus.DONE !== 2'b00 || bus.BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_state: gnt=%b done=%b busy=%b want 00/00/1",
                  bus.GNT, bus.DONE, bus.BUSY);
      end
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      #1;
      n = 0;
      saw_done = 0;
      while (bus.BUSY === 1'b1 && n < 100) begin
         if (bus.DONE !== 2'b00) saw_done = 1;
         n++;
         @(negedge CLK);
      end
      n_checks++;
      if (saw_done || n != 16) begin
         n_fail++;
         $display("FAIL midrst_flush: done_seen=%0d busy=%0d want 0/16", saw_done, n);
      end
      bus.REQ_DATA = '0;
      bus.REQ = 2'b01;
      @(negedge CLK);
      wait_done(k, to);
      n_checks++;
      if (to || bus.DONE !== 2'b01) begin
         n_fail++;
         $display("FAIL midrst_done: done=%b want 01", bus.DONE);
      end
      bus.REQ = '0;
      @(negedge CLK);
      n_checks++;
      if (bus.RESULT !== 16'h0) begin
         n_fail++;
         $display("FAIL midrst_result: result=%h want 0000", bus.RESULT);
      end
   endtask

   initial begin
      test_reset();
      test_zero_job();
      test_stream();
      test_data_change();
      test_round_robin();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
